cond_flag_unit: RTL and testbench

Condition-flag controller for the ARM core: accepts flag-setting compare operations (CMP, CMN, TST, TEQ) over a valid/ready handshake, sequences each through a calculate and a write-back stage, and owns the architectural NZCV register. It also evaluates 4-bit ARM condition codes against committed flags for conditional execution. While a flag update is in flight, condition requests stall.

---
 rtl/cond_flag_unit.sv | 191 +++++++++++++++++++
 tb/tb_cond_flag_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: owns the architectural NZCV register, sequences flag-setting
// compares (CMP/CMN/TST/TEQ) through CALC and WRITE stages, and evaluates ARM
// condition codes against the committed flags. Condition requests stall while
// a flag update is in flight.
module cond_flag_unit #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cmp_valid,
  output logic         o_cmp_ready,
  input  logic [1:0]   i_cmp_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cond_valid,
  input  logic [3:0]   i_cond,
  output logic         o_cond_ready,
  output logic         o_cond_pass_valid,
  output logic         o_cond_pass,
  output logic [3:0]   o_flags,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [1:0] OP_CMP = 2'b00;
  localparam logic [1:0] OP_CMN = 2'b01;
  localparam logic [1:0] OP_TST = 2'b10;
  localparam logic [1:0] OP_TEQ = 2'b11;

  // Flags are packed {N,Z,C,V}: bit3=N, bit2=Z, bit1=C, bit0=V.
  function automatic logic cond_eval(input logic [3:0] flags, input logic [3:0] cond);
    logic fn, fz, fc, fv;
    fn = flags[3];
    fz = flags[2];
    fc = flags[1];
    fv = flags[0];
    case (cond)
      4'd0:    cond_eval = fz;
      4'd1:    cond_eval = ~fz;
      4'd2:    cond_eval = fc;
      4'd3:    cond_eval = ~fc;
      4'd4:    cond_eval = fn;
      4'd5:    cond_eval = ~fn;
      4'd6:    cond_eval = fv;
      4'd7:    cond_eval = ~fv;
      4'd8:    cond_eval = fc & ~fz;
      4'd9:    cond_eval = ~fc | fz;
      4'd10:   cond_eval = (fn == fv);
      4'd11:   cond_eval = (fn != fv);
      4'd12:   cond_eval = ~fz & (fn == fv);
      4'd13:   cond_eval = fz | (fn != fv);
      4'd14:   cond_eval = 1'b1;
      4'd15:   cond_eval = 1'b0;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  state_t       state_r, state_next_s;
  logic [1:0]   op_r;
  logic [N-1:0] a_r, b_r;
  logic [3:0]   pending_r;
  logic [3:0]   flags_r;
  logic         pass_valid_r, pass_r;
  logic [N:0]   res_s;
  logic         c_s, v_s;
  logic [3:0]   cand_flags_s;
  logic         cmp_accept_s, cond_accept_s;

  assign cmp_accept_s  = i_cmp_valid  && (state_r == ST_IDLE);
  assign cond_accept_s = i_cond_valid && (state_r == ST_IDLE);

  // State register for the compare sequencer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= ST_IDLE;
    else          state_r <= state_next_s;
  end

  // Next-state logic: one accepted compare walks IDLE -> CALC -> WRITE -> IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (i_cmp_valid) state_next_s = ST_CALC;
                else             state_next_s = ST_IDLE;
      ST_CALC:  state_next_s = ST_WRITE;
      ST_WRITE: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: both request channels are only open in IDLE.
  always_comb begin
    o_cmp_ready  = 1'b0;
    o_cond_ready = 1'b0;
    o_busy       = 1'b1;
    case (state_r)
      ST_IDLE: begin
        o_cmp_ready  = 1'b1;
        o_cond_ready = 1'b1;
        o_busy       = 1'b0;
      end
      ST_CALC, ST_WRITE: begin
        o_cmp_ready  = 1'b0;
        o_cond_ready = 1'b0;
        o_busy       = 1'b1;
      end
      default: begin
        o_cmp_ready  = 1'b0;
        o_cond_ready = 1'b0;
        o_busy       = 1'b1;
      end
    endcase
  end

  // Capture the compare operation and operands at acceptance only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_r <= OP_CMP;
      a_r  <= {N{1'b0}};
      b_r  <= {N{1'b0}};
    end else if (cmp_accept_s) begin
      op_r <= i_cmp_op;
      a_r  <= i_a;
      b_r  <= i_b;
    end else begin
      op_r <= op_r;
      a_r  <= a_r;
      b_r  <= b_r;
    end
  end

  // Candidate flags from the captured operands; logical ops keep committed C and V.
  always_comb begin
    res_s = {(N+1){1'b0}};
    c_s   = flags_r[1];
    v_s   = flags_r[0];
    case (op_r)
      OP_CMP: begin
        res_s = {1'b0, a_r} - {1'b0, b_r};
        c_s   = ~res_s[N];
        v_s   = (a_r[N-1] != b_r[N-1]) && (res_s[N-1] != a_r[N-1]);
      end
      OP_CMN: begin
        res_s = {1'b0, a_r} + {1'b0, b_r};
        c_s   = res_s[N];
        v_s   = (a_r[N-1] == b_r[N-1]) && (res_s[N-1] != a_r[N-1]);
      end
      OP_TST: res_s = {1'b0, a_r & b_r};
      OP_TEQ: res_s = {1'b0, a_r ^ b_r};
      default: res_s = {(N+1){1'b0}};
    endcase
    cand_flags_s = {res_s[N-1], (res_s[N-1:0] == {N{1'b0}}), c_s, v_s};
  end

  // Pending flags are loaded in CALC and committed in WRITE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_r <= 4'b0000;
      flags_r   <= 4'b0000;
    end else begin
      if (state_r == ST_CALC) pending_r <= cand_flags_s;
      else                    pending_r <= pending_r;
      if (state_r == ST_WRITE) flags_r <= pending_r;
      else                     flags_r <= flags_r;
    end
  end

  // Condition result: a one-cycle registered pulse, evaluated on the flags
  // committed at acceptance (older than any compare accepted alongside it).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pass_valid_r <= 1'b0;
      pass_r       <= 1'b0;
    end else if (cond_accept_s) begin
      pass_valid_r <= 1'b1;
      pass_r       <= cond_eval(flags_r, i_cond);
    end else begin
      pass_valid_r <= 1'b0;
      pass_r       <= 1'b0;
    end
  end

  assign o_flags           = flags_r;
  assign o_cond_pass_valid = pass_valid_r;
  assign o_cond_pass       = pass_r;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed testbench for cond_flag_unit with hand-computed expected flags.
module tb_cond_flag_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_cmp_valid;
  logic        o_cmp_ready;
  logic [1:0]  i_cmp_op;
  logic [31:0] i_a, i_b;
  logic        i_cond_valid;
  logic [3:0]  i_cond;
  logic        o_cond_ready;
  logic        o_cond_pass_valid;
  logic        o_cond_pass;
  logic [3:0]  o_flags;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] model_flags = 4'b0000;

  cond_flag_unit #(.N(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmp_valid(i_cmp_valid), .o_cmp_ready(o_cmp_ready), .i_cmp_op(i_cmp_op),
    .i_a(i_a), .i_b(i_b),
    .i_cond_valid(i_cond_valid), .i_cond(i_cond), .o_cond_ready(o_cond_ready),
    .o_cond_pass_valid(o_cond_pass_valid), .o_cond_pass(o_cond_pass),
    .o_flags(o_flags), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One compare; optionally raises a condition request right after acceptance
  // to observe the hazard stall.
  task automatic do_cmp(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] exp_flags,
                        input logic hold_cond, input logic [3:0] cond);
    int waited;
    waited = 0;
    while (o_cmp_ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    check_eq({tag, "_ready"}, {31'd0, o_cmp_ready}, 32'd1);
    i_cmp_valid = 1'b1; i_cmp_op = op; i_a = a; i_b = b;
    tick(); // E0: accepted
    i_cmp_valid = 1'b0; i_a = 32'hDEAD_BEEF; i_b = 32'h1234_5678;
    if (hold_cond) begin
      i_cond_valid = 1'b1; i_cond = cond;
    end
    check_eq({tag, "_busy_calc"}, {31'd0, o_busy}, 32'd1);
    check_eq({tag, "_cmpready_calc"}, {31'd0, o_cmp_ready}, 32'd0);
    if (hold_cond) begin
      check_eq({tag, "_condready_calc"}, {31'd0, o_cond_ready}, 32'd0);
      check_eq({tag, "_passvalid_calc"}, {31'd0, o_cond_pass_valid}, 32'd0);
    end
    tick(); // E1: pending registered, flags unchanged
    check_eq({tag, "_flags_e1"}, {28'd0, o_flags}, {28'd0, model_flags});
    if (hold_cond) begin
      check_eq({tag, "_condready_write"}, {31'd0, o_cond_ready}, 32'd0);
      check_eq({tag, "_passvalid_write"}, {31'd0, o_cond_pass_valid}, 32'd0);
    end
    tick(); // E2: flags committed
    model_flags = exp_flags;
    check_eq({tag, "_flags"}, {28'd0, o_flags}, {28'd0, exp_flags});
    check_eq({tag, "_busy_done"}, {31'd0, o_busy}, 32'd0);
    check_eq({tag, "_cmpready_done"}, {31'd0, o_cmp_ready}, 32'd1);
  endtask

  task automatic do_cond(input string tag, input logic [3:0] cond, input logic exp);
    i_cond_valid = 1'b1; i_cond = cond;
    check_eq({tag, "_condready"}, {31'd0, o_cond_ready}, 32'd1);
    tick();
    i_cond_valid = 1'b0; i_cond = 4'd0;
    check_eq({tag, "_passvalid"}, {31'd0, o_cond_pass_valid}, 32'd1);
    check_eq({tag, "_pass"}, {31'd0, o_cond_pass}, {31'd0, exp});
    tick();
    check_eq({tag, "_pulse_end"}, {31'd0, o_cond_pass_valid}, 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_cmp_valid = 1'b0; i_cmp_op = 2'b00; i_a = 32'd0; i_b = 32'd0;
    i_cond_valid = 1'b0; i_cond = 4'd0;
    #2;
    check_eq("rst_flags", {28'd0, o_flags}, 32'd0);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_passvalid", {31'd0, o_cond_pass_valid}, 32'd0);
    check_eq("rst_pass", {31'd0, o_cond_pass}, 32'd0);
    check_eq("rst_cmpready", {31'd0, o_cmp_ready}, 32'd1);
    tick(); tick();
    i_rst_n = 1'b1;
    // Payload with valid low must not start a compare.
    i_cmp_op = 2'b00; i_a = 32'd3; i_b = 32'd7;
    tick(); tick();
    check_eq("novalid_busy", {31'd0, o_busy}, 32'd0);
    check_eq("novalid_flags", {28'd0, o_flags}, 32'd0);

    do_cmp("cmp_5_5", 2'b00, 32'd5, 32'd5, 4'b0110, 1'b0, 4'd0);
    do_cond("eq_a", 4'd0, 1'b1);
    do_cond("ne_a", 4'd1, 1'b0);

    do_cmp("cmp_min_1", 2'b00, 32'h8000_0000, 32'd1, 4'b0011, 1'b0, 4'd0);
    do_cond("lt", 4'd11, 1'b1);
    do_cond("ge", 4'd10, 1'b0);

    do_cmp("cmn_ff_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 4'b0110, 1'b0, 4'd0);
    do_cmp("tst", 2'b10, 32'h0000_00F0, 32'h0000_000F, 4'b0110, 1'b0, 4'd0);
    do_cmp("teq", 2'b11, 32'h8000_0000, 32'd0, 4'b1010, 1'b0, 4'd0);
    do_cond("hi", 4'd8, 1'b1);

    // CMP 3,7 with CC raised during CALC; it is accepted once IDLE returns.
    do_cmp("cmp_3_7", 2'b00, 32'd3, 32'd7, 4'b1000, 1'b1, 4'd3);
    check_eq("cc_condready_idle", {31'd0, o_cond_ready}, 32'd1);
    tick();
    i_cond_valid = 1'b0;
    check_eq("cc_passvalid", {31'd0, o_cond_pass_valid}, 32'd1);
    check_eq("cc_pass", {31'd0, o_cond_pass}, 32'd1);
    tick();
    do_cond("nv", 4'd15, 1'b0);
    do_cond("al", 4'd14, 1'b1);
    do_cond("le", 4'd13, 1'b1);

    // Reset during WRITE of CMP 3,7 discards the update.
    i_cmp_valid = 1'b1; i_cmp_op = 2'b00; i_a = 32'd3; i_b = 32'd7;
    tick(); // E0
    i_cmp_valid = 1'b0;
    tick(); // E1: now in WRITE
    check_eq("rstw_busy_before", {31'd0, o_busy}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    check_eq("rstw_flags", {28'd0, o_flags}, 32'd0);
    check_eq("rstw_busy", {31'd0, o_busy}, 32'd0);
    tick();
    check_eq("rstw_flags_held", {28'd0, o_flags}, 32'd0);
    i_rst_n = 1'b1;
    model_flags = 4'b0000;
    tick();
    check_eq("rstw_cmpready", {31'd0, o_cmp_ready}, 32'd1);
    check_eq("rstw_flags_after", {28'd0, o_flags}, 32'd0);

    // Simultaneous compare and condition: EQ sees old flags 0000.
    i_cmp_valid = 1'b1; i_cmp_op = 2'b00; i_a = 32'd1; i_b = 32'd1;
    i_cond_valid = 1'b1; i_cond = 4'd0;
    tick();
    i_cmp_valid = 1'b0; i_cond_valid = 1'b0;
    check_eq("sim_passvalid", {31'd0, o_cond_pass_valid}, 32'd1);
    check_eq("sim_eq_old", {31'd0, o_cond_pass}, 32'd0);
    check_eq("sim_busy", {31'd0, o_busy}, 32'd1);
    tick();
    check_eq("sim_flags_e1", {28'd0, o_flags}, 32'd0);
    tick();
    check_eq("sim_flags", {28'd0, o_flags}, 32'h6);
    do_cond("eq_b", 4'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
